// File: rtl/constants_pkg.sv
// constants_pkg: ALU operation codes, instruction opcodes and instruction field positions
package constants_pkg;
  typedef enum logic [1:0] {REG_READ, REG_WRITE, ADD, SUB} ALUOp;
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_LOADI = 4'h3,
    OP_OUT   = 4'h4,
    OP_HALT  = 4'hF
  } opcode_t;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RR_MSB  = 11;
  localparam int RR_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational decode of an instruction word into ALU op, register addresses and immediate
module instr_decoder
  import constants_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic [15:0]          ir,
  output ALUOp                 op,
  output logic [3:0]           addr_a,
  output logic [3:0]           addr_b,
  output logic [3:0]           addr_r,
  output logic [DATA_BITS-1:0] imm,
  output logic                 illegal,
  output logic                 halt
);
  logic [3:0] opc;
  logic       alu, rd_only;
  assign opc = ir[OPC_MSB:OPC_LSB];
  // fields not used by an opcode are driven to zero
  always_comb begin
    alu     = opc == OP_ADD || opc == OP_SUB;
    rd_only = opc == OP_LOADI || opc == OP_OUT;
    op      = opc == OP_ADD ? ADD : opc == OP_SUB ? SUB : opc == OP_LOADI ? REG_WRITE : REG_READ;
    addr_r  = alu ? ir[RR_MSB:RR_LSB] : '0;
    addr_a  = alu ? ir[RA_MSB:RA_LSB] : rd_only ? ir[RR_MSB:RR_LSB] : '0;
    addr_b  = alu ? ir[RB_MSB:RB_LSB] : '0;
    imm     = opc == OP_LOADI ? DATA_BITS'(ir[IMM_MSB:IMM_LSB]) : '0;
    illegal = opc inside {[4'h5:4'hE]};
    halt    = opc == OP_HALT;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/issue controller feeding the ALU+register-file stage
module instr_sequencer
  import constants_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PC_BITS    = 8,
  parameter int INSTR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [PC_BITS-1:0]    mem_addr,
  output logic                  mem_rd_req,
  input  logic                  mem_rd_valid,
  input  logic [INSTR_BITS-1:0] mem_rd_data,
  output ALUOp                  op,
  output logic [3:0]            addr_a,
  output logic [3:0]            addr_b,
  output logic [3:0]            addr_r,
  output logic [DATA_BITS-1:0]  data_out,
  output logic                  halted,
  output logic                  illegal,
  output logic [PC_BITS-1:0]    pc
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, SETTLE, HALTED} state_t;
  state_t                 state, nxt;
  logic [INSTR_BITS-1:0]  ir;
  ALUOp                   dec_op;
  logic [3:0]             dec_a, dec_b, dec_r;
  logic [DATA_BITS-1:0]   dec_imm;
  logic                   dec_ill, dec_halt;
  instr_decoder #(.DATA_BITS(DATA_BITS)) u_dec (
    .ir(ir),
    .op(dec_op),
    .addr_a(dec_a),
    .addr_b(dec_b),
    .addr_r(dec_r),
    .imm(dec_imm),
    .illegal(dec_ill),
    .halt(dec_halt)
  );
  // state register; reset drops straight back to IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state: one instruction takes FETCH (>=1 cycle), DECODE, EXEC, SETTLE
  always_comb
    nxt = state == IDLE   ? (start ? FETCH : IDLE) :
          state == FETCH  ? (mem_rd_valid ? DECODE : FETCH) :
          state == DECODE ? EXEC :
          state == EXEC   ? SETTLE :
          state == SETTLE ? (dec_halt ? HALTED : FETCH) : HALTED;
  // outputs decoded from state so reset removes any request or write immediately
  always_comb begin
    mem_rd_req = state == FETCH;
    mem_addr   = state == FETCH ? pc : '0;
    op         = state == EXEC ? dec_op : REG_READ;
    halted     = state == HALTED;
  end
  // instruction latch, issue fields held through EXEC and SETTLE, pc and sticky illegal flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir       <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      addr_r   <= '0;
      data_out <= '0;
      illegal  <= 1'b0;
      pc       <= '0;
    end else begin
      if (state == FETCH && mem_rd_valid) ir <= mem_rd_data;
      if (state == DECODE) begin
        addr_a   <= dec_a;
        addr_b   <= dec_b;
        addr_r   <= dec_r;
        data_out <= dec_imm;
      end
      if (state == EXEC && dec_ill) illegal <= 1'b1;
      if (state == SETTLE && !dec_halt) pc <= pc + 1'b1;
    end
endmodule
